// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus bundle.
// Groups the per-cycle control inputs (stall, redirect, debug request), the
// instruction memory read port and the fetch/decode boundary outputs.
//   master : the fetch sequencer side
//   slave  : the environment side (decode, branch unit, debug loader, imem)
interface fetch_sequencer_if #(
  parameter int XLEN               = 64,
  parameter int INSTRUCTION_LENGTH = XLEN / 2
);
  logic                          stall;
  logic                          redirect_valid;
  logic [XLEN-1:0]               redirect_target;
  logic                          dbg_req;
  logic                          dbg_grant;
  logic [XLEN-1:0]               imem_addr;
  logic [INSTRUCTION_LENGTH-1:0] imem_instr;
  logic [XLEN-1:0]               pc_out;
  logic [INSTRUCTION_LENGTH-1:0] instr_out;
  logic                          instr_valid;
  logic                          fetch_fault;

  modport master (
    input  stall, redirect_valid, redirect_target, dbg_req, imem_instr,
    output dbg_grant, imem_addr, pc_out, instr_out, instr_valid, fetch_fault
  );

  modport slave (
    output stall, redirect_valid, redirect_target, dbg_req, imem_instr,
    input  dbg_grant, imem_addr, pc_out, instr_out, instr_valid, fetch_fault
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch stage sequencer.
// Owns the fetch PC, drives the instruction memory address combinationally
// and registers PC + instruction into the fetch/decode boundary. Shares the
// memory port with a debug loader, and handles stall, branch redirect and a
// boot delay after reset.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - asynchronous active-low reset
//   bus  - fetch_sequencer_if.master (control inputs, imem port, decode outputs)
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   : misaligned redirect target sets sticky fetch_fault and halts
//   undefined : redirect target low bits are cleared, fetch_fault tied 0
module fetch_sequencer #(
  parameter int              XLEN               = 64,
  parameter int              INSTRUCTION_LENGTH = XLEN / 2,
  parameter logic [XLEN-1:0] RESET_VECTOR       = '0,
  parameter int              BOOT_DELAY         = 1
) (
  input logic               clk,
  input logic               rst,
  fetch_sequencer_if.master bus
);

  localparam int CNT_W = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY) : 1;
  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_DELAY - 1);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_DEBUG, S_HALT} state_e;

  state_e                        state_q, state_d;
  logic [CNT_W-1:0]              boot_cnt_q, boot_cnt_d;
  logic [XLEN-1:0]               fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]               pc_out_q, pc_out_d;
  logic [INSTRUCTION_LENGTH-1:0] instr_out_q, instr_out_d;
  logic                          instr_valid_q, instr_valid_d;
  logic                          dbg_grant_q, dbg_grant_d;

  logic [XLEN-1:0] redir_pc;
  logic            trap;

  // Redirect targets are forced to word alignment in the normal path.
  assign redir_pc = bus.redirect_target & ~XLEN'(3);

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_q, fault_d;
  assign trap            = bus.redirect_valid && (bus.redirect_target[1:0] != 2'b00);
  assign bus.fetch_fault = fault_q;
`else
  assign trap            = 1'b0;
  assign bus.fetch_fault = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    boot_cnt_d    = boot_cnt_q;
    fetch_pc_d    = fetch_pc_q;
    pc_out_d      = pc_out_q;
    instr_out_d   = instr_out_q;
    instr_valid_d = instr_valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    fault_d       = fault_q;
`endif

    case (state_q)
      S_BOOT: begin
        // Inputs are ignored until the boot delay has elapsed.
        instr_valid_d = 1'b0;
        boot_cnt_d    = boot_cnt_q + CNT_W'(1);
        if (boot_cnt_q == BOOT_LAST) state_d = S_RUN;
      end

      S_RUN: begin
        if (trap) begin
          state_d       = S_HALT;
          fetch_pc_d    = bus.redirect_target;
          instr_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
          fault_d       = 1'b1;
`endif
        end else if (bus.redirect_valid) begin
          // One bubble; the decode registers keep the last instruction.
          fetch_pc_d    = redir_pc;
          instr_valid_d = 1'b0;
        end else if (bus.dbg_req) begin
          // fetch_pc is held so fetch resumes at the same address.
          state_d       = S_DEBUG;
          instr_valid_d = 1'b0;
        end else if (!bus.stall) begin
          pc_out_d      = fetch_pc_q;
          instr_out_d   = bus.imem_instr;
          instr_valid_d = 1'b1;
          fetch_pc_d    = fetch_pc_q + XLEN'(4);
        end
      end

      S_DEBUG: begin
        instr_valid_d = 1'b0;
        if (trap) begin
          state_d    = S_HALT;
          fetch_pc_d = bus.redirect_target;
`ifdef FETCH_MISALIGN_TRAP_EN
          fault_d    = 1'b1;
`endif
        end else begin
          // Redirects still land while the loader owns the port.
          if (bus.redirect_valid) fetch_pc_d = redir_pc;
          if (!bus.dbg_req)       state_d    = S_RUN;
        end
      end

      default: begin
        // HALT: frozen until reset.
        instr_valid_d = 1'b0;
      end
    endcase

    // Grant follows the registered state so it rises on the entry edge
    // and falls on the exit edge.
    dbg_grant_d = (state_d == S_DEBUG);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_BOOT;
      boot_cnt_q    <= '0;
      fetch_pc_q    <= RESET_VECTOR;
      pc_out_q      <= '0;
      instr_out_q   <= '0;
      instr_valid_q <= 1'b0;
      dbg_grant_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      boot_cnt_q    <= boot_cnt_d;
      fetch_pc_q    <= fetch_pc_d;
      pc_out_q      <= pc_out_d;
      instr_out_q   <= instr_out_d;
      instr_valid_q <= instr_valid_d;
      dbg_grant_q   <= dbg_grant_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fault_q <= 1'b0;
    else      fault_q <= fault_d;
  end
`endif

  assign bus.imem_addr   = fetch_pc_q;
  assign bus.pc_out      = pc_out_q;
  assign bus.instr_out   = instr_out_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.dbg_grant   = dbg_grant_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed scenarios with fixed expectations,
// then randomized traffic checked against a transaction-level model.
module tb_fetch_sequencer;
  localparam int          XLEN = 64;
  localparam int          ILEN = 32;
  localparam logic [63:0] RV   = 64'h0;
  localparam int          BD   = 1;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] instr;
    logic        grant;
    logic        fault;
    logic [63:0] addr;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  fetch_sequencer_if #(.XLEN(XLEN), .INSTRUCTION_LENGTH(ILEN)) bus ();

  fetch_sequencer #(
    .XLEN(XLEN), .INSTRUCTION_LENGTH(ILEN), .RESET_VECTOR(RV), .BOOT_DELAY(BD)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_f(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32];
  endfunction

  assign bus.imem_instr = mem_f(bus.imem_addr);

  // Reference model: what has been fetched and where fetch goes next.
  int          m_boot_left;
  bit          m_in_debug, m_halted, m_fault, m_valid;
  logic [63:0] m_next_pc, m_pc;
  logic [31:0] m_instr;

  function automatic obs_t sample_dut();
    return '{bus.instr_valid, bus.pc_out, bus.instr_out, bus.dbg_grant,
             bus.fetch_fault, bus.imem_addr};
  endfunction

  function automatic obs_t model_out();
    return '{m_valid, m_pc, m_instr, m_in_debug, m_fault, m_next_pc};
  endfunction

  task automatic model_reset();
    m_boot_left = BD;
    m_in_debug  = 0;
    m_halted    = 0;
    m_fault     = 0;
    m_valid     = 0;
    m_next_pc   = RV;
    m_pc        = '0;
    m_instr     = '0;
  endtask

  task automatic clear_inputs();
    bus.stall           = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;
    bus.dbg_req         = 1'b0;
  endtask

  // One clock: capture the inputs seen by this edge, step the model, and
  // leave time 1 unit past the edge for sampling.
  task automatic tick();
    bit          s, rv, dq, mis;
    logic [63:0] rt;
    s = bus.stall; rv = bus.redirect_valid; rt = bus.redirect_target; dq = bus.dbg_req;
    mis = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
    mis = rv && (rt[1:0] != 2'b00);
`endif
    @(posedge clk);
    if (m_boot_left > 0) begin
      m_boot_left--;
    end else if (!m_halted) begin
      if (mis) begin
        m_halted = 1; m_fault = 1; m_in_debug = 0; m_valid = 0; m_next_pc = rt;
      end else if (m_in_debug) begin
        if (rv) m_next_pc = {rt[63:2], 2'b00};
        if (!dq) m_in_debug = 0;
      end else if (rv) begin
        m_next_pc = {rt[63:2], 2'b00};
        m_valid   = 0;
      end else if (dq) begin
        m_in_debug = 1;
        m_valid    = 0;
      end else if (!s) begin
        m_pc      = m_next_pc;
        m_instr   = mem_f(m_next_pc);
        m_valid   = 1;
        m_next_pc = m_next_pc + 64'd4;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    model_reset();
    #3;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    obs_t got, exp;
    clear_inputs();
    model_reset();
    rst = 1'b0;
    #3;
    exp = '{1'b0, 64'h0, 32'h0, 1'b0, 1'b0, RV};
    got = sample_dut(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_values: got %h expected %h", got, exp); end
    // Inputs during reset must not matter.
    bus.redirect_valid = 1'b1; bus.redirect_target = 64'h400; bus.dbg_req = 1'b1;
    @(posedge clk); #1;
    got = sample_dut(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_held: got %h expected %h", got, exp); end
    clear_inputs();
    #3;
    rst = 1'b1;
  endtask

  task automatic test_boot_stream_stall();
    obs_t got, exp;
    tick();
    exp = '{1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 64'h0};
    got = sample_dut(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL boot_bubble: got %h expected %h", got, exp); end
    for (int i = 0; i < 3; i++) begin
      tick();
      exp = '{1'b1, 64'(4*i), mem_f(64'(4*i)), 1'b0, 1'b0, 64'(4*i+4)};
      got = sample_dut(); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL boot_stream%0d: got %h expected %h", i, got, exp); end
    end
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp = '{1'b1, 64'h8, mem_f(64'h8), 1'b0, 1'b0, 64'hC};
      got = sample_dut(); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL stall_hold%0d: got %h expected %h", i, got, exp); end
    end
    bus.stall = 1'b0;
    tick();
    exp = '{1'b1, 64'hC, mem_f(64'hC), 1'b0, 1'b0, 64'h10};
    got = sample_dut(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL stall_release: got %h expected %h", got, exp); end
  endtask

  task automatic test_redirect_over_stall();
    obs_t got, exp;
    bus.stall = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_target = 64'h100;
    tick();
    exp = '{1'b0, 64'hC, mem_f(64'hC), 1'b0, 1'b0, 64'h100};
    got = sample_dut(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL redirect_bubble: got %h expected %h", got, exp); end
    clear_inputs();
    for (int i = 0; i < 2; i++) begin
      tick();
      exp = '{1'b1, 64'(256+4*i), mem_f(64'(256+4*i)), 1'b0, 1'b0, 64'(260+4*i)};
      got = sample_dut(); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL redirect_stream%0d: got %h expected %h", i, got, exp); end
    end
  endtask

  task automatic test_debug();
    obs_t got, exp;
    bus.redirect_valid = 1'b1; bus.redirect_target = 64'h10;
    tick();
    clear_inputs();
    tick();
    exp = '{1'b1, 64'h10, mem_f(64'h10), 1'b0, 1'b0, 64'h14};
    got = sample_dut(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL debug_setup: got %h expected %h", got, exp); end
    bus.dbg_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      exp = '{1'b0, 64'h10, mem_f(64'h10), 1'b1, 1'b0, 64'h14};
      got = sample_dut(); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL debug_owned%0d: got %h expected %h", i, got, exp); end
    end
    bus.dbg_req = 1'b0;
    tick();
    exp = '{1'b0, 64'h10, mem_f(64'h10), 1'b0, 1'b0, 64'h14};
    got = sample_dut(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL debug_exit: got %h expected %h", got, exp); end
    tick();
    exp = '{1'b1, 64'h14, mem_f(64'h14), 1'b0, 1'b0, 64'h18};
    got = sample_dut(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL debug_resume: got %h expected %h", got, exp); end
  endtask

  task automatic test_wrap();
    obs_t got, exp;
    bus.redirect_valid = 1'b1; bus.redirect_target = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    clear_inputs();
    tick();
    exp = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFC, mem_f(64'hFFFF_FFFF_FFFF_FFFC), 1'b0, 1'b0, 64'h0};
    got = sample_dut(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL wrap_top: got %h expected %h", got, exp); end
    tick();
    exp = '{1'b1, 64'h0, mem_f(64'h0), 1'b0, 1'b0, 64'h4};
    got = sample_dut(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL wrap_zero: got %h expected %h", got, exp); end
  endtask

  task automatic test_misalign();
    obs_t got, exp;
    bus.redirect_valid = 1'b1; bus.redirect_target = 64'h102;
    tick();
`ifdef FETCH_MISALIGN_TRAP_EN
    exp = '{1'b0, 64'h0, mem_f(64'h0), 1'b0, 1'b1, 64'h102};
    got = sample_dut(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL misalign_trap: got %h expected %h", got, exp); end
    for (int i = 0; i < 4; i++) begin
      bus.redirect_valid = 1'(i & 1); bus.redirect_target = 64'h200;
      bus.dbg_req = 1'(i >> 1); bus.stall = 1'b0;
      tick();
      got = sample_dut(); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL halt_frozen%0d: got %h expected %h", i, got, exp); end
    end
    do_reset();
    exp = '{1'b0, 64'h0, 32'h0, 1'b0, 1'b0, RV};
    got = sample_dut(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL halt_reset: got %h expected %h", got, exp); end
`else
    exp = '{1'b0, 64'h0, mem_f(64'h0), 1'b0, 1'b0, 64'h100};
    got = sample_dut(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL misalign_clear: got %h expected %h", got, exp); end
    clear_inputs();
    tick();
    exp = '{1'b1, 64'h100, mem_f(64'h100), 1'b0, 1'b0, 64'h104};
    got = sample_dut(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL misalign_fetch: got %h expected %h", got, exp); end
`endif
  endtask

  task automatic test_dbg_in_boot();
    obs_t got, exp;
    do_reset();
    bus.dbg_req = 1'b1;
    tick();
    exp = '{1'b0, 64'h0, 32'h0, 1'b0, 1'b0, RV};
    got = sample_dut(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL dbg_boot_ignored: got %h expected %h", got, exp); end
    tick();
    exp = '{1'b0, 64'h0, 32'h0, 1'b1, 1'b0, RV};
    got = sample_dut(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL dbg_after_boot: got %h expected %h", got, exp); end
    bus.dbg_req = 1'b0;
    tick();
    tick();
    exp = '{1'b1, RV, mem_f(RV), 1'b0, 1'b0, RV + 64'd4};
    got = sample_dut(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL dbg_boot_first: got %h expected %h", got, exp); end
  endtask

  task automatic test_midop_reset();
    obs_t got, exp;
    bus.dbg_req = 1'b1;
    tick();
    bus.redirect_valid = 1'b1; bus.redirect_target = 64'h800;
    rst = 1'b0;
    model_reset();
    #1;
    exp = '{1'b0, 64'h0, 32'h0, 1'b0, 1'b0, RV};
    got = sample_dut(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL async_reset: got %h expected %h", got, exp); end
    clear_inputs();
    #2;
    rst = 1'b1;
    tick();
    tick();
    exp = '{1'b1, RV, mem_f(RV), 1'b0, 1'b0, RV + 64'd4};
    got = sample_dut(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL redirect_lost: got %h expected %h", got, exp); end
  endtask

  task automatic test_random();
    obs_t got, exp;
    int   shown = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(199) == 0) do_reset();
      bus.stall          = ($urandom_range(3) == 0);
      bus.redirect_valid = ($urandom_range(7) == 0);
      case ($urandom_range(9))
        0:       bus.redirect_target = 64'hFFFF_FFFF_FFFF_FF00 | 64'($urandom_range(255));
        1:       bus.redirect_target = 64'($urandom_range(4095));
        default: bus.redirect_target = 64'($urandom_range(4095)) & ~64'h3;
      endcase
      if ($urandom_range(9) == 0) bus.dbg_req = ~bus.dbg_req;
      tick();
      got = sample_dut();
      exp = model_out();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        if (shown < 10) $display("FAIL random_c%0d: got %h expected %h", c, got, exp);
        shown++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_boot_stream_stall();
    test_redirect_over_stall();
    test_debug();
    test_wrap();
    test_misalign();
    test_dbg_in_boot();
    test_midop_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Controls the fetch stage. Owns the fetch PC and drives the instruction memory address, and registers PC and instruction into the fetch/decode boundary. Arbitrates the instruction memory port between normal fetch and the debug loader. Also handles stall, branch redirect and boot delay after reset.

Parameters:
XLEN, 64, address/PC width
INSTRUCTION_LENGTH, XLEN/2, instruction width
RESET_VECTOR, 0, first fetch address after reset
BOOT_DELAY, 1, cycles held in BOOT after reset release (>=1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low
stall  in  1  decode cannot accept; hold fetch/decode registers
redirect_valid  in  1  branch/jump taken; load redirect_target
redirect_target  in  XLEN  new fetch address
dbg_req  in  1  debug loader requests instruction memory port
dbg_grant  out  1  debug owns memory port; fetch suspended
imem_addr  out  XLEN  instruction memory read address (= fetch_pc)
imem_instr  in  INSTRUCTION_LENGTH  combinational memory read data for imem_addr
pc_out  out  XLEN  PC of instruction presented to decode
instr_out  out  INSTRUCTION_LENGTH  instruction presented to decode
instr_valid  out  1  pc_out/instr_out valid
fetch_fault  out  1  sticky fault flag (optional feature only; else tied 0)

Behaviour:
- States: BOOT, RUN, DEBUG, HALT (HALT reachable only with feature enabled).
- Reset asserted (rst=0, async): state=BOOT, fetch_pc=RESET_VECTOR, boot counter=0, pc_out=0, instr_out=0, instr_valid=0, dbg_grant=0, fetch_fault=0.
- BOOT: counter increments each cycle; instr_valid=0; inputs ignored. Move to RUN on the edge where counter reaches BOOT_DELAY-1.
- imem_addr = fetch_pc at all times (combinational); memory read is zero-latency.
- RUN, per-cycle priority: redirect > dbg_req > stall > advance.
  - redirect_valid: fetch_pc<=redirect_target with bits[1:0] cleared; instr_valid<=0 (one bubble); pc_out/instr_out hold. Redirect beats stall.
  - dbg_req (no redirect): state<=DEBUG, instr_valid<=0, fetch_pc held.
  - stall (no redirect/dbg): fetch_pc, pc_out, instr_out, instr_valid all hold.
  - advance: pc_out<=fetch_pc, instr_out<=imem_instr, instr_valid<=1, fetch_pc<=fetch_pc+4.
- First valid instruction: pc_out=RESET_VECTOR, appearing BOOT_DELAY+1 cycles after reset release.
- fetch_pc+4 wraps modulo 2^XLEN (max-4 -> 0); no flag raised.
- DEBUG: dbg_grant=1 (registered, asserted the cycle after entry); instr_valid=0. redirect_valid is still accepted and updates fetch_pc. dbg_req=0 -> RUN next edge, with dbg_grant deasserting on the same edge. Fetch resumes at the held/redirected fetch_pc with no skipped or duplicate PC.
- dbg_req asserted in BOOT: no effect until RUN.
- Reset mid-operation in any state: immediate return to reset values; an in-flight redirect is lost.

Optional Feature:
FETCH_MISALIGN_TRAP_EN
- Defined: a redirect with redirect_target[1:0]!=0 sets fetch_fault=1 (sticky until reset) and moves to HALT. HALT: instr_valid=0, fetch_pc frozen at the unaligned target, all inputs ignored except reset.
- Undefined: low bits silently cleared; fetch_fault tied 0; HALT unused.

Test Plan:
- Reset release, BOOT_DELAY=1, no stall -> instr_valid rises 2nd cycle with pc_out=0, then 4, 8, 12 on consecutive cycles.
- stall high 3 cycles while pc_out=8 -> pc_out=8, instr_valid=1 held 3 cycles; next cycle pc_out=12.
- redirect_valid with target 0x100 while stall=1 -> one cycle instr_valid=0, then pc_out=0x100, 0x104.
- dbg_req high 5 cycles from pc_out=0x10 -> dbg_grant=1 and instr_valid=0 during DEBUG; after release pc_out=0x14 with no gap or repeat.
- fetch_pc=2^64-4 advancing -> pc_out=0xFFFF_FFFF_FFFF_FFFC, then 0.
- Redirect to 0x102: without macro -> pc_out=0x100 and fetch_fault=0; with FETCH_MISALIGN_TRAP_EN -> fetch_fault=1, instr_valid=0 until rst pulsed low.
